// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I core: sequences fetch, decode, address generation,
// execute and writeback over the shared ALU and unified memory port.
module multicycle_controller (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       adr_src_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic [1:0] result_select_o,
    output logic [1:0] alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] immediate_select_o,
    output logic [2:0] alu_control_o,
    output logic       reg_write_o,
    output logic       illegal_o
);

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecR,
        StExecI,
        StAluWb,
        StBeq,
        StJal,
        StHalt
    } state_e;

    localparam logic [6:0] OpLw  = 7'b0000011;
    localparam logic [6:0] OpSw  = 7'b0100011;
    localparam logic [6:0] OpR   = 7'b0110011;
    localparam logic [6:0] OpI   = 7'b0010011;
    localparam logic [6:0] OpBeq = 7'b1100011;
    localparam logic [6:0] OpJal = 7'b1101111;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluSlt = 3'b101;

    state_e     state_q, state_d;
    logic       funct_ok;
    logic [2:0] alu_funct;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    assign funct_ok = (funct3_i == 3'b000) || (funct3_i == 3'b010) ||
                      (funct3_i == 3'b110) || (funct3_i == 3'b111);

    always_comb begin
        alu_funct = AluAdd;
        case (funct3_i)
            3'b000:  alu_funct = ((opcode_i == OpR) && funct7b5_i) ? AluSub : AluAdd;
            3'b010:  alu_funct = AluSlt;
            3'b110:  alu_funct = AluOr;
            3'b111:  alu_funct = AluAnd;
            default: alu_funct = AluAdd;
        endcase
    end

    always_comb begin
        immediate_select_o = 2'b00;
        case (opcode_i)
            OpSw:    immediate_select_o = 2'b01;
            OpBeq:   immediate_select_o = 2'b10;
            OpJal:   immediate_select_o = 2'b11;
            default: immediate_select_o = 2'b00;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        pc_write_o      = 1'b0;
        adr_src_o       = 1'b0;
        mem_write_o     = 1'b0;
        ir_write_o      = 1'b0;
        result_select_o = 2'b00;
        alu_src_a_o     = 2'b00;
        alu_src_b_o     = 2'b00;
        alu_control_o   = AluAdd;
        reg_write_o     = 1'b0;
        illegal_o       = 1'b0;

        case (state_q)
            StFetch: begin
                // PC + 4 goes straight to the PC through the live ALU result
                alu_src_b_o     = 2'b10;
                result_select_o = 2'b10;
                ir_write_o      = mem_ready_i;
                pc_write_o      = mem_ready_i;
                state_d         = mem_ready_i ? StDecode : StFetch;
            end
            StDecode: begin
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b01;
                case (opcode_i)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpR:        state_d = funct_ok ? StExecR : StHalt;
                    OpI:        state_d = funct_ok ? StExecI : StHalt;
                    OpBeq:      state_d = StBeq;
                    OpJal:      state_d = StJal;
                    default:    state_d = StHalt;
                endcase
            end
            StMemAdr: begin
                alu_src_a_o = 2'b10;
                alu_src_b_o = 2'b01;
                if (opcode_i == OpLw) begin
                    state_d = StMemRead;
                end else if (opcode_i == OpSw) begin
                    state_d = StMemWrite;
                end else begin
                    state_d = StHalt;
                end
            end
            StMemRead: begin
                adr_src_o = 1'b1;
                state_d   = mem_ready_i ? StMemWb : StMemRead;
            end
            StMemWb: begin
                result_select_o = 2'b01;
                reg_write_o     = 1'b1;
                state_d         = StFetch;
            end
            StMemWrite: begin
                adr_src_o   = 1'b1;
                mem_write_o = 1'b1;
                state_d     = mem_ready_i ? StFetch : StMemWrite;
            end
            StExecR: begin
                alu_src_a_o   = 2'b10;
                alu_control_o = alu_funct;
                state_d       = StAluWb;
            end
            StExecI: begin
                alu_src_a_o   = 2'b10;
                alu_src_b_o   = 2'b01;
                alu_control_o = alu_funct;
                state_d       = StAluWb;
            end
            StAluWb: begin
                reg_write_o = 1'b1;
                state_d     = StFetch;
            end
            StBeq: begin
                // Target was precomputed into the ALU-out register during decode
                alu_src_a_o   = 2'b10;
                alu_control_o = AluSub;
                pc_write_o    = zero_i;
                state_d       = StFetch;
            end
            StJal: begin
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b10;
                pc_write_o  = 1'b1;
                state_d     = StAluWb;
            end
            StHalt: begin
                illegal_o = 1'b1;
                state_d   = StHalt;
            end
            default: begin
                state_d = StHalt;
            end
        endcase
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Moore-style control FSM that sequences the shared datapath of the multicycle RV32I core. One ALU and one unified memory port are reused across cycles for fetch, address generation, execution and writeback. The block sits beside the datapath and drives every datapath mux select and write strobe. Supported instructions are lw, sw, R-type ALU, I-type ALU, beq and jal. It stalls on a memory-ready handshake and parks in a halt state on unsupported encodings.

## Interface
Parameters: none.
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; forces state to FETCH
- opcode  input  7  instruction[6:0] from the instruction register
- funct3  input  3  instruction[14:12]
- funct7b5  input  1  instruction[30]
- zero  input  1  ALU result == 0
- mem_ready  input  1  memory access completes this cycle
- pc_write  output  1  load PC from result bus
- adr_src  output  1  memory address: 0 = PC, 1 = result bus
- mem_write  output  1  memory write strobe
- ir_write  output  1  load instruction register and old_pc
- result_select  output  2  00 = ALU-out register, 01 = data register, 10 = live ALU result
- alu_src_a  output  2  00 = PC, 01 = old_pc, 10 = rd1
- alu_src_b  output  2  00 = rd2, 01 = immediate, 10 = constant 4
- immediate_select  output  2  00 I, 01 S, 10 B, 11 J; matches the extend unit encoding
- alu_control  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- reg_write  output  1  register file write strobe
- illegal  output  1  high while in HALT

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, HALT.
- Opcode map:
  - lw = 0000011
  - sw = 0100011
  - R = 0110011
  - I = 0010011
  - beq = 1100011
  - jal = 1101111
- immediate_select is combinational from opcode in every state: lw/I → 00, sw → 01, beq → 10, jal → 11, other → 00.
- Default output value is 0 unless listed below.
- FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, add, result_select=10.
  - ir_write and pc_write are set to mem_ready.
  - Next state is DECODE if mem_ready, else FETCH.
- DECODE: alu_src_a=01, alu_src_b=01, add (precomputes the branch/jump target).
  - Next state: lw/sw → MEMADR, R → EXECR, I → EXECI, beq → BEQ, jal → JAL, other → HALT.
- MEMADR: alu_src_a=10, alu_src_b=01, add. Next state is MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: adr_src=1, result_select=00. Next state is MEMWB if mem_ready, else MEMREAD.
- MEMWB: result_select=01, reg_write=1. Next state is FETCH.
- MEMWRITE: adr_src=1, result_select=00, mem_write=1 (held until accepted). Next state is FETCH if mem_ready, else MEMWRITE.
- EXECR: alu_src_a=10, alu_src_b=00, ALU decoded from funct. Next state is ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, ALU decoded from funct. Next state is ALUWB.
- ALU funct decode (EXECR/EXECI):
  - funct3 000: sub if R-type and funct7b5=1, else add.
  - funct3 010: slt.
  - funct3 110: or.
  - funct3 111: and.
  - Any other funct3: decoded as add. In DECODE, an R/I opcode with an unsupported funct3 goes to HALT instead.
- ALUWB: result_select=00, reg_write=1. Next state is FETCH.
- BEQ: alu_src_a=10, alu_src_b=00, sub, result_select=00, pc_write=zero. Next state is FETCH.
- JAL: alu_src_a=01, alu_src_b=10, add, result_select=00, pc_write=1. Next state is ALUWB (writes old_pc+4 to rd).
- HALT: all strobes 0, illegal=1. Stays in HALT until reset.

## Timing
- Outputs are decoded from the state register only. The exceptions are the mem_ready gating in FETCH and the zero gating in BEQ, which are combinational.
- While reset is high: state=FETCH and illegal=0. All strobes are 0 except that ir_write and pc_write follow mem_ready.
- Zero-wait cycle counts per instruction:
  - lw: 5
  - sw: 4
  - R, I, jal: 4
  - beq: 3
- Each cycle with mem_ready low in FETCH, MEMREAD or MEMWRITE adds one cycle. The stall holds all outputs stable.
- Deasserting reset mid-instruction resumes at FETCH with the PC unchanged by the controller. No strobe pulses on reset release.
- opcode, funct3 and funct7b5 must be stable from DECODE to the end of the instruction (the instruction register is written only in FETCH).

## Test plan
- Reset with mem_ready=1, release, opcode=0110011, funct3=000, funct7b5=1:
  - Expected state sequence: FETCH, DECODE, EXECR, ALUWB, FETCH.
  - alu_control=001 in EXECR; reg_write=1 only in ALUWB.
- lw with mem_ready low for 2 cycles in MEMREAD: lw takes 7 cycles total, and reg_write pulses once with result_select=01.
- sw with mem_ready low for 3 cycles: mem_write stays high for 4 consecutive cycles with adr_src=1, then the FSM returns to FETCH.
- beq with zero=1: pc_write=1 in BEQ. With zero=0: pc_write=0. Both return to FETCH after 3 cycles.
- jal: pc_write=1 in JAL, then ALUWB with reg_write=1. immediate_select=11 throughout.
- opcode=1111111: HALT after DECODE with illegal=1 and no strobes for 10 cycles. Asserting reset mid-HALT returns to FETCH with illegal=0 immediately.
